rtc_frame_sequencer: RTL and testbench

//  Sending end of the RTC-to-display load sequence. On each frame tick it reads the 8 RTC

---
 rtl/rtc_frame_sequencer.sv | 184 ++++++++++++++++++
 tb/tb_rtc_frame_sequencer.sv | 289 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/rtc_frame_sequencer.sv
// rtc_frame_sequencer
//   On every accepted frame tick, reads the eight RTC registers (sec, min, hour,
//   date, month, year, day, week) over a req/ack bus into a shadow buffer, then
//   streams them to the display side as a framed burst: one header cycle, eight
//   data bytes in address order, and a configurable tail.
//
// Ports
//   clk             system clock, rising edge
//   reset           asynchronous, active-low
//   frame_tick      1-cycle pulse, starts a fetch+send cycle when idle
//   rtc_rd          read request to the RTC bus controller
//   rtc_addr        RTC register index being read
//   rtc_ack         1-cycle pulse, rtc_dato valid for current rtc_addr
//   rtc_dato        RTC read data
//   inicioSecuencia load-sequence frame towards the display
//   datoRTC         streamed byte (0x00 outside data slots)
//   busy            high whenever the sequencer is not idle
//   overrun         1-cycle pulse: frame_tick arrived while busy (dropped)
//   timeout_err     sticky: some read was abandoned since reset
//
// state | meaning
// IDLE  | waiting for frame_tick
// RD    | rtc_rd high, waiting for ack or timeout
// GAP   | one cycle with rtc_rd low between reads
// HDR   | header cycle of the display frame, datoRTC=0x00
// DATA  | eight cycles streaming the shadow buffer
// TAIL  | trailing frame cycles, datoRTC=0x00
module rtc_frame_sequencer #(
  parameter int TIMEOUT     = 16,
  parameter int TAIL_CYCLES = 3
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       frame_tick,
  output logic       rtc_rd,
  output logic [2:0] rtc_addr,
  input  logic       rtc_ack,
  input  logic [7:0] rtc_dato,
  output logic       inicioSecuencia,
  output logic [7:0] datoRTC,
  output logic       busy,
  output logic       overrun,
  output logic       timeout_err
);

  // One shared counter covers the read wait, the data slot index and the tail.
  localparam int CNT_MAX0 = (TIMEOUT > 8) ? TIMEOUT : 8;
  localparam int CNT_MAX  = (TAIL_CYCLES > CNT_MAX0) ? TAIL_CYCLES : CNT_MAX0;
  localparam int CW       = $clog2(CNT_MAX + 1);

  localparam logic [CW-1:0] RD_LAST   = CW'(TIMEOUT - 1);
  localparam logic [CW-1:0] DATA_LAST = CW'(7);
  localparam logic [CW-1:0] TAIL_LAST = CW'((TAIL_CYCLES > 0) ? TAIL_CYCLES - 1 : 0);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_RD,
    ST_GAP,
    ST_HDR,
    ST_DATA,
    ST_TAIL
  } state_t;

  state_t          state_q, state_d;
  logic [2:0]      idx_q, idx_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [7:0]      shadow_q [8];
  logic            cap_en;
  logic            terr_q, terr_d;

  logic            rd_q, rd_d;
  logic [2:0]      addr_q;
  logic            inicio_q, inicio_d;
  logic [7:0]      dato_q, dato_d;
  logic            busy_q, busy_d;

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    cnt_d   = cnt_q;
    cap_en  = 1'b0;
    terr_d  = terr_q;

    unique case (state_q)
      ST_IDLE: begin
        if (frame_tick) begin
          state_d = ST_RD;
          idx_d   = 3'd0;
          cnt_d   = '0;
        end
      end
      ST_RD: begin
        // An ack on the limit cycle still counts as a successful read.
        if (rtc_ack) begin
          cap_en  = 1'b1;
          state_d = ST_GAP;
        end else if (cnt_q == RD_LAST) begin
          terr_d  = 1'b1;
          state_d = ST_GAP;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      ST_GAP: begin
        if (idx_q == 3'd7) begin
          state_d = ST_HDR;
          idx_d   = 3'd0;
        end else begin
          state_d = ST_RD;
          idx_d   = idx_q + 3'd1;
          cnt_d   = '0;
        end
      end
      ST_HDR: begin
        state_d = ST_DATA;
        cnt_d   = '0;
      end
      ST_DATA: begin
        if (cnt_q == DATA_LAST) begin
          cnt_d   = '0;
          state_d = (TAIL_CYCLES == 0) ? ST_IDLE : ST_TAIL;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      ST_TAIL: begin
        if (cnt_q == TAIL_LAST) begin
          state_d = ST_IDLE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    // Outputs are flopped from the next-state decode so they line up with the
    // state they describe. The shadow buffer never changes while streaming, so
    // shadow_q already holds the byte for the upcoming data slot.
    rd_d     = (state_d == ST_RD);
    inicio_d = (state_d == ST_HDR) || (state_d == ST_DATA) || (state_d == ST_TAIL);
    dato_d   = (state_d == ST_DATA) ? shadow_q[cnt_d[2:0]] : 8'h00;
    busy_d   = (state_d != ST_IDLE);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= ST_IDLE;
      idx_q    <= 3'd0;
      cnt_q    <= '0;
      terr_q   <= 1'b0;
      rd_q     <= 1'b0;
      addr_q   <= 3'd0;
      inicio_q <= 1'b0;
      dato_q   <= 8'h00;
      busy_q   <= 1'b0;
      for (int i = 0; i < 8; i++) begin
        shadow_q[i] <= 8'h00;
      end
    end else begin
      state_q  <= state_d;
      idx_q    <= idx_d;
      cnt_q    <= cnt_d;
      terr_q   <= terr_d;
      rd_q     <= rd_d;
      addr_q   <= idx_d;
      inicio_q <= inicio_d;
      dato_q   <= dato_d;
      busy_q   <= busy_d;
      if (cap_en) begin
        shadow_q[idx_q] <= rtc_dato;
      end
    end
  end

  assign rtc_rd          = rd_q;
  assign rtc_addr        = addr_q;
  assign inicioSecuencia = inicio_q;
  assign datoRTC         = dato_q;
  assign busy            = busy_q;
  assign timeout_err     = terr_q;
  // Only output allowed to react combinationally to an input.
  assign overrun         = frame_tick && (state_q != ST_IDLE);

endmodule

// File: tb/tb_rtc_frame_sequencer.sv
// Testbench for rtc_frame_sequencer: a random RTC responder follows a per-frame
// plan, a frame-level reference model turns that plan into expected read
// lengths, header cycle, streamed bytes and error flag, and a monitor compares.
module tb_rtc_frame_sequencer;
  localparam int TIMEOUT = 16;
  localparam int TAIL    = 3;

  logic       clk = 1'b0;
  logic       reset;
  logic       frame_tick;
  logic       rtc_rd;
  logic [2:0] rtc_addr;
  logic       rtc_ack;
  logic [7:0] rtc_dato;
  logic       inicioSecuencia;
  logic [7:0] datoRTC;
  logic       busy;
  logic       overrun;
  logic       timeout_err;

  rtc_frame_sequencer #(.TIMEOUT(TIMEOUT), .TAIL_CYCLES(TAIL)) dut (
    .clk(clk), .reset(reset), .frame_tick(frame_tick),
    .rtc_rd(rtc_rd), .rtc_addr(rtc_addr), .rtc_ack(rtc_ack), .rtc_dato(rtc_dato),
    .inicioSecuencia(inicioSecuencia), .datoRTC(datoRTC), .busy(busy),
    .overrun(overrun), .timeout_err(timeout_err)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int total = 0;
  int bad   = 0;

  task automatic chk(input string nm, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Per-frame plan: dly[a] = RD cycle index on which ack arrives, -1 = never.
  int         dly [8];
  logic [7:0] val [8];

  // Reference model state.
  logic [7:0] sh_m [8];
  bit         terr_m;

  int exp_byte_q[$];
  int exp_hdr_q[$];
  int exp_len_q[$];
  int exp_addr_q[$];
  int exp_terr_q[$];

  task automatic push_frame(input int t);
    int hdr;
    int len;
    hdr = t + 1;
    for (int a = 0; a < 8; a++) begin
      len = (dly[a] < 0) ? TIMEOUT : dly[a] + 1;
      exp_addr_q.push_back(a);
      exp_len_q.push_back(len);
      hdr += len + 1;
      if (dly[a] >= 0) sh_m[a] = val[a];
      else terr_m = 1'b1;
    end
    exp_hdr_q.push_back(hdr);
    exp_byte_q.push_back(0);
    for (int a = 0; a < 8; a++) exp_byte_q.push_back(int'(sh_m[a]));
    for (int i = 0; i < TAIL; i++) exp_byte_q.push_back(0);
    exp_terr_q.push_back(int'(terr_m));
  endtask

  // RTC responder.
  bit resp_on = 1'b0;
  int rc = 0;
  initial begin
    rtc_ack  = 1'b0;
    rtc_dato = 8'h00;
    forever begin
      @(negedge clk);
      if (!reset) begin
        resp_on  = 1'b0;
        rtc_ack  = 1'b0;
      end else if (rtc_rd) begin
        if (!resp_on) begin
          resp_on = 1'b1;
          rc = 0;
        end else begin
          rc++;
        end
        if (dly[rtc_addr] >= 0 && rc == dly[rtc_addr]) begin
          rtc_ack  = 1'b1;
          rtc_dato = val[rtc_addr];
        end else begin
          rtc_ack  = 1'b0;
          rtc_dato = 8'($urandom);
        end
      end else begin
        // Stray acks outside a read must be ignored by the DUT.
        resp_on  = 1'b0;
        rtc_ack  = ($urandom_range(0, 3) == 0);
        rtc_dato = 8'($urandom);
      end
    end
  end

  // Monitor.
  bit in_frame = 1'b0;
  bit rd_on    = 1'b0;
  int run_len  = 0;
  int rd_len   = 0;
  int rd_addr  = 0;
  initial begin
    forever begin
      @(negedge clk);
      if (reset) begin
        if (inicioSecuencia) begin
          if (!in_frame) begin
            in_frame = 1'b1;
            run_len  = 0;
            chk("hdr_expected", int'(exp_hdr_q.size() > 0), 1);
            if (exp_hdr_q.size() > 0) chk("hdr_cycle", cyc, exp_hdr_q.pop_front());
          end
          chk("byte_expected", int'(exp_byte_q.size() > 0), 1);
          if (exp_byte_q.size() > 0) chk("stream_byte", int'(datoRTC), exp_byte_q.pop_front());
          run_len++;
        end else begin
          chk("dato_zero_outside_frame", int'(datoRTC), 0);
          if (in_frame) begin
            in_frame = 1'b0;
            chk("inicio_len", run_len, 9 + TAIL);
            chk("terr_expected", int'(exp_terr_q.size() > 0), 1);
            if (exp_terr_q.size() > 0) chk("timeout_err", int'(timeout_err), exp_terr_q.pop_front());
          end
        end
        if (rtc_rd) begin
          if (!rd_on) begin
            rd_on  = 1'b1;
            rd_len = 0;
            rd_addr = int'(rtc_addr);
            chk("rd_expected", int'(exp_addr_q.size() > 0), 1);
            if (exp_addr_q.size() > 0) chk("rd_addr", rd_addr, exp_addr_q.pop_front());
          end else begin
            chk("rd_addr_stable", int'(rtc_addr), rd_addr);
          end
          rd_len++;
        end else if (rd_on) begin
          rd_on = 1'b0;
          chk("len_expected", int'(exp_len_q.size() > 0), 1);
          if (exp_len_q.size() > 0) chk("rd_len", rd_len, exp_len_q.pop_front());
        end
      end
    end
  end

  task automatic wait_inicio();
    int n = 0;
    while (!inicioSecuencia && n < 1000) begin
      @(negedge clk);
      n++;
    end
    chk("wait_inicio_bound", int'(inicioSecuencia), 1);
  endtask

  task automatic start_frame();
    @(negedge clk);
    push_frame(cyc);
    frame_tick = 1'b1;
    #1 chk("overrun_idle_tick", int'(overrun), 0);
    @(negedge clk);
    frame_tick = 1'b0;
  endtask

  task automatic run_frame(input bit ovr);
    int n = 0;
    start_frame();
    if (ovr) begin
      wait_inicio();
      repeat (3) @(negedge clk);
      frame_tick = 1'b1;
      #1 chk("overrun_pulse", int'(overrun), 1);
      @(negedge clk);
      frame_tick = 1'b0;
      #1 chk("overrun_clear", int'(overrun), 0);
    end
    while (busy && n < 2000) begin
      @(negedge clk);
      n++;
    end
    chk("frame_end_bound", int'(busy), 0);
    repeat (6) @(negedge clk);
    chk("idle_after_frame", int'(busy), 0);
    chk("bytes_drained", exp_byte_q.size(), 0);
    chk("reads_drained", exp_len_q.size(), 0);
  endtask

  task automatic rand_plan(input int max_dly, input bit allow_to);
    for (int a = 0; a < 8; a++) begin
      val[a] = 8'($urandom);
      if (allow_to && $urandom_range(0, 5) == 0) dly[a] = -1;
      else dly[a] = int'($urandom_range(0, max_dly));
    end
  endtask

  initial begin
    reset      = 1'b0;
    frame_tick = 1'b0;
    for (int a = 0; a < 8; a++) begin
      dly[a]  = 0;
      val[a]  = 8'h00;
      sh_m[a] = 8'h00;
    end
    terr_m = 1'b0;

    // Reset values.
    #23;
    chk("rst_rtc_rd", int'(rtc_rd), 0);
    chk("rst_rtc_addr", int'(rtc_addr), 0);
    chk("rst_inicio", int'(inicioSecuencia), 0);
    chk("rst_dato", int'(datoRTC), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_overrun", int'(overrun), 0);
    chk("rst_terr", int'(timeout_err), 0);
    @(negedge clk);
    reset = 1'b1;
    repeat (5) @(negedge clk);
    chk("idle_busy", int'(busy), 0);
    chk("idle_rd", int'(rtc_rd), 0);
    chk("idle_inicio", int'(inicioSecuencia), 0);

    // Nominal frame, ack one cycle into each read.
    val[0] = 8'h24; val[1] = 8'h04; val[2] = 8'h03; val[3] = 8'h23;
    val[4] = 8'h12; val[5] = 8'h17; val[6] = 8'h05; val[7] = 8'h04;
    for (int a = 0; a < 8; a++) dly[a] = 1;
    run_frame(1'b0);

    // Ack on first RD cycle: header lands 17 cycles after the tick.
    rand_plan(0, 1'b0);
    run_frame(1'b0);

    // Ack on the timeout limit cycle for the year register.
    rand_plan(3, 1'b0);
    dly[5] = TIMEOUT - 1;
    run_frame(1'b0);

    // Reset while the fourth data byte is on the bus.
    rand_plan(2, 1'b0);
    start_frame();
    wait_inicio();
    repeat (4) @(negedge clk);
    #2 reset = 1'b0;
    #1;
    chk("abort_inicio", int'(inicioSecuencia), 0);
    chk("abort_dato", int'(datoRTC), 0);
    chk("abort_busy", int'(busy), 0);
    chk("abort_rd", int'(rtc_rd), 0);
    exp_byte_q.delete(); exp_hdr_q.delete(); exp_len_q.delete();
    exp_addr_q.delete(); exp_terr_q.delete();
    in_frame = 1'b0;
    rd_on    = 1'b0;
    for (int a = 0; a < 8; a++) sh_m[a] = 8'h00;
    terr_m = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b1;
    repeat (3) @(negedge clk);

    // Fresh frame after reset with the hour read timing out.
    rand_plan(2, 1'b0);
    dly[2] = -1;
    run_frame(1'b0);

    // Tick during DATA is dropped and flagged.
    rand_plan(3, 1'b0);
    run_frame(1'b1);

    // Random frames.
    for (int f = 0; f < 6; f++) begin
      rand_plan(TIMEOUT - 1, 1'b1);
      run_frame(f[0]);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
